// File: rtl/code_lock_pkg.sv
// Shared types and width helper for the parametrised keypad code lock.
package code_lock_pkg;

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        OPEN    = 2'd1,
        PROG    = 2'd2,
        LOCKOUT = 2'd3
    } lock_state_e;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter that saturates at zero; serves both the unlock window and the lockout.
module lock_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)               count <= '0;
        else if (load)         count <= load_val;
        else if (count != '0)  count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/param_code_lock.sv
// Keypad code lock: full-length code entry, timed unlock window, reprogramming, and failure lockout.
module param_code_lock
    import code_lock_pkg::*;
#(
    parameter int SYM_W        = 2,
    parameter int CODE_LEN     = 5,
    parameter     DEFAULT_CODE = 10'b01_01_00_01_00,
    parameter int UNLOCK_CYC   = 256,
    parameter int MAX_FAIL     = 3,
    parameter int LOCKOUT_CYC  = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sym_valid,
    input  logic [SYM_W-1:0]              sym,
    input  logic                          prog_req,
    output logic                          unlock,
    output logic                          lockout,
    output logic                          prog_active,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

    localparam int IW   = cnt_w(CODE_LEN);
    localparam int TMAX = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
    localparam int TW   = cnt_w(TMAX);
    localparam logic [CODE_LEN-1:0][SYM_W-1:0] RST_CODE = DEFAULT_CODE;

    if ($bits(DEFAULT_CODE) != SYM_W * CODE_LEN) begin : g_bad_code
        $error("DEFAULT_CODE width must equal SYM_W*CODE_LEN");
    end
    if (UNLOCK_CYC < 1 || LOCKOUT_CYC < 1) begin : g_bad_cyc
        $error("UNLOCK_CYC and LOCKOUT_CYC must be at least 1");
    end
    if (CODE_LEN < 1 || MAX_FAIL < 1) begin : g_bad_len
        $error("CODE_LEN and MAX_FAIL must be at least 1");
    end

    lock_state_e                    state, state_n;
    logic [CODE_LEN-1:0][SYM_W-1:0] code_reg;
    logic [IW-1:0]                  idx;
    logic                           mismatch;
    logic                           sym_miss, last, entry_done, go_open, go_lock;
    logic                           tmr_load, tmr_zero;
    logic [TW-1:0]                  tmr_val;

    lock_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // A wrong symbol only marks the attempt; the verdict comes on the last symbol.
    always_comb begin
        sym_miss   = mismatch | (sym != code_reg[idx]);
        last       = (idx == IW'(CODE_LEN - 1));
        entry_done = (state == ENTRY) && sym_valid && last;
        go_open    = entry_done && !sym_miss;
        go_lock    = entry_done && sym_miss && (int'(fail_cnt) + 1 >= MAX_FAIL);
        tmr_load   = go_open | go_lock;
        tmr_val    = go_open ? TW'(UNLOCK_CYC - 1) : TW'(LOCKOUT_CYC - 1);

        state_n = state;
        case (state)
            ENTRY:   if (go_open) state_n = OPEN;
                     else if (go_lock) state_n = LOCKOUT;
            OPEN:    if (tmr_zero) state_n = ENTRY;
                     else if (prog_req) state_n = PROG;
            PROG:    if (sym_valid && last) state_n = ENTRY;
            LOCKOUT: if (tmr_zero) state_n = ENTRY;
            default: state_n = ENTRY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ENTRY;
            code_reg    <= RST_CODE;
            idx         <= '0;
            mismatch    <= 1'b0;
            fail_cnt    <= '0;
            unlock      <= 1'b0;
            lockout     <= 1'b0;
            prog_active <= 1'b0;
        end else begin
            state       <= state_n;
            unlock      <= (state_n == OPEN);
            lockout     <= (state_n == LOCKOUT);
            prog_active <= (state_n == PROG);
            case (state)
                ENTRY: if (sym_valid) begin
                    if (last) begin
                        idx      <= '0;
                        mismatch <= 1'b0;
                        if (go_open)      fail_cnt <= '0;
                        else if (go_lock) fail_cnt <= ($clog2(MAX_FAIL+1))'(MAX_FAIL);
                        else              fail_cnt <= fail_cnt + 1'b1;
                    end else begin
                        idx      <= idx + 1'b1;
                        mismatch <= sym_miss;
                    end
                end
                OPEN: if (!tmr_zero && prog_req) idx <= '0;
                PROG: if (sym_valid) begin
                    code_reg[idx] <= sym;
                    idx           <= last ? '0 : idx + 1'b1;
                end
                LOCKOUT: if (tmr_zero) begin
                    fail_cnt <= '0;
                    idx      <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_param_code_lock.sv
// Bench for param_code_lock: directed scenarios plus randomized traffic against a queue-based model.
module tb_param_code_lock;

    localparam int SYM_W       = 2;
    localparam int CODE_LEN    = 5;
    localparam int UNLOCK_CYC  = 8;
    localparam int MAX_FAIL    = 3;
    localparam int LOCKOUT_CYC = 16;
    localparam logic [9:0] DEF_CODE = 10'b01_01_00_01_00;  // 0,1,0,1,1
    localparam logic [9:0] BAD_CODE = 10'b01_01_01_01_00;  // 0,1,1,1,1
    localparam logic [9:0] NEW_CODE = 10'b11_00_01_10_11;  // 3,2,1,0,3
    localparam int M_ENTRY = 0, M_OPEN = 1, M_PROG = 2, M_LOCK = 3;

    logic             clk, rst, sym_valid, prog_req;
    logic [SYM_W-1:0] sym;
    logic             unlock, lockout, prog_active;
    logic [1:0]       fail_cnt;

    param_code_lock #(
        .SYM_W(SYM_W), .CODE_LEN(CODE_LEN), .DEFAULT_CODE(DEF_CODE),
        .UNLOCK_CYC(UNLOCK_CYC), .MAX_FAIL(MAX_FAIL), .LOCKOUT_CYC(LOCKOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym(sym), .prog_req(prog_req),
        .unlock(unlock), .lockout(lockout), .prog_active(prog_active), .fail_cnt(fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int unl_cycles, lk_cycles;

    // Behavioural model: mode, entered-symbol queue, stored code, remaining window.
    int         m_mode, m_fail, m_left, m_pidx;
    int         m_q[$];
    logic [1:0] m_code[CODE_LEN];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_mode = M_ENTRY; m_fail = 0; m_left = 0; m_pidx = 0;
        m_q.delete();
        for (int i = 0; i < CODE_LEN; i++) m_code[i] = DEF_CODE[2*i +: 2];
    endfunction

    function automatic void model_update(input logic v, input logic [1:0] s, input logic p);
        bit ok;
        case (m_mode)
            M_ENTRY: if (v) begin
                m_q.push_back(int'(s));
                if (m_q.size() == CODE_LEN) begin
                    ok = 1'b1;
                    for (int i = 0; i < CODE_LEN; i++) if (m_q[i] != int'(m_code[i])) ok = 1'b0;
                    m_q.delete();
                    if (ok) begin
                        m_mode = M_OPEN; m_left = UNLOCK_CYC; m_fail = 0;
                    end else begin
                        m_fail++;
                        if (m_fail == MAX_FAIL) begin m_mode = M_LOCK; m_left = LOCKOUT_CYC; end
                    end
                end
            end
            M_OPEN: begin
                m_left--;
                if (m_left == 0) m_mode = M_ENTRY;
                else if (p) begin m_mode = M_PROG; m_pidx = 0; end
            end
            M_PROG: if (v) begin
                m_code[m_pidx] = s;
                m_pidx++;
                if (m_pidx == CODE_LEN) m_mode = M_ENTRY;
            end
            default: begin
                m_left--;
                if (m_left == 0) begin m_mode = M_ENTRY; m_fail = 0; end
            end
        endcase
    endfunction

    // One clock: drive at negedge, update model at posedge, compare 1 time unit later.
    task automatic step(input logic v, input logic [1:0] s, input logic p);
        sym_valid = v; sym = s; prog_req = p;
        @(posedge clk);
        model_update(v, s, p);
        #1;
        chk("unlock",      unlock,      m_mode == M_OPEN);
        chk("lockout",     lockout,     m_mode == M_LOCK);
        chk("prog_active", prog_active, m_mode == M_PROG);
        chk("fail_cnt",    fail_cnt,    m_fail);
        if (unlock)  unl_cycles++;
        if (lockout) lk_cycles++;
        @(negedge clk);
        sym_valid = 1'b0; prog_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 2'd0, 1'b0);
    endtask

    task automatic enter(input logic [9:0] w, input int max_gap);
        for (int i = 0; i < CODE_LEN; i++) begin
            idle($urandom_range(0, max_gap));
            step(1'b1, w[2*i +: 2], 1'b0);
        end
    endtask

    // Reset asserted between clock edges; outputs must clear without waiting for an edge.
    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        chk({tag, "_rst_unlock"},  unlock,      0);
        chk({tag, "_rst_lockout"}, lockout,     0);
        chk({tag, "_rst_prog"},    prog_active, 0);
        chk({tag, "_rst_fail"},    fail_cnt,    0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sym_valid = 1'b0; sym = '0; prog_req = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_unlock",  unlock,      0);
        chk("reset_lockout", lockout,     0);
        chk("reset_prog",    prog_active, 0);
        chk("reset_fail",    fail_cnt,    0);
        rst = 1'b0;
        idle(2);

        // 1: correct code, window length
        unl_cycles = 0;
        enter(DEF_CODE, 2);
        chk("t1_unlock", unlock, 1);
        chk("t1_fail", fail_cnt, 0);
        idle(12);
        chk("t1_window", unl_cycles, 8);

        // 2: wrong code, then correct
        enter(BAD_CODE, 1);
        chk("t2_unlock", unlock, 0);
        chk("t2_fail", fail_cnt, 1);
        enter(DEF_CODE, 1);
        chk("t2_unlock2", unlock, 1);
        chk("t2_fail2", fail_cnt, 0);
        idle(10);

        // 3: lockout after three failures, input ignored while locked
        lk_cycles = 0;
        repeat (3) enter(BAD_CODE, 0);
        chk("t3_lockout", lockout, 1);
        chk("t3_fail", fail_cnt, 3);
        enter(DEF_CODE, 0);
        chk("t3_ignored", unlock, 0);
        idle(20);
        chk("t3_duration", lk_cycles, 16);
        chk("t3_fail_clr", fail_cnt, 0);

        // 4: reprogram, old code fails, new code works
        enter(DEF_CODE, 0);
        step(1'b0, 2'd0, 1'b1);
        chk("t4_prog", prog_active, 1);
        enter(NEW_CODE, 1);
        chk("t4_prog_done", prog_active, 0);
        enter(DEF_CODE, 1);
        chk("t4_old_fail", fail_cnt, 1);
        enter(NEW_CODE, 1);
        chk("t4_new_unlock", unlock, 1);
        idle(10);

        // 5: async reset mid-entry and mid-programming
        enter(BAD_CODE, 0);
        chk("t5_fail_pre", fail_cnt, 1);
        for (int i = 0; i < 3; i++) step(1'b1, DEF_CODE[2*i +: 2], 1'b0);
        do_reset("t5a");
        enter(DEF_CODE, 0);
        chk("t5_unlock_a", unlock, 1);
        step(1'b0, 2'd0, 1'b1);
        step(1'b1, 2'd3, 1'b0);
        step(1'b1, 2'd3, 1'b0);
        do_reset("t5b");
        enter(DEF_CODE, 1);
        chk("t5_unlock_b", unlock, 1);
        idle(10);

        // 6: prog_req on the last open cycle is dropped
        enter(DEF_CODE, 0);
        idle(7);
        chk("t6_last_open", unlock, 1);
        step(1'b0, 2'd0, 1'b1);
        chk("t6_unlock", unlock, 0);
        chk("t6_prog", prog_active, 0);
        idle(1);
        chk("t6_prog_later", prog_active, 0);

        // Randomized traffic, biased toward the currently stored code
        for (int n = 0; n < 3000; n++) begin
            logic       v, p;
            logic [1:0] s;
            v = ($urandom_range(0, 2) != 0);
            p = ($urandom_range(0, 11) == 0);
            if (m_mode == M_ENTRY && $urandom_range(0, 3) != 0) s = m_code[m_q.size()];
            else s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 799) == 0) do_reset("rnd");
            else step(v, s, p);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
